except_ctrl: RTL and testbench
==============================

Name: except_ctrl

Overview:
- Registered exception resolution and commit controller in the MEM stage of the pipelined MIPS CPU.
- Each cycle it collects the per-instruction exception flags and the hardware interrupt lines, and resolves one exception by fixed priority.
- On commit it produces a one-cycle exception pulse, a multi-cycle pipeline flush, the redirect PC, and the values CP0 writes: EPC, BadVAddr, BD and ExcCode.
- Generalises the combinational exception-type encoder with a parametrised interrupt width, input synchronisers, a stall-aware commit and a flush state machine.

Parameters:
- HW_INT_N, 6, number of hardware interrupt lines (1..6), mapped to Cause/Status bits [10 +: HW_INT_N].
- SYNC_STAGES, 2, flip-flop stages on each hw_int line (≥1).
- FLUSH_CYCLES, 1, number of cycles flush stays high per commit (1..15).
- EXC_VEC, 32'hBFC00380, exception handler entry address.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- valid_m  in  1  MEM stage holds a real instruction
- stall_m  in  1  MEM stage stalled; no commit this cycle
- except_m  in  8  [7] fetch AdEL, [6] break, [5] syscall, [4] eret, [3] RI, [2] Ov, [1] load AdEL, [0] store AdES
- pc_m  in  32  PC of the MEM-stage instruction
- bad_addr_m  in  32  data address of the MEM-stage load/store
- in_ds_m  in  1  MEM-stage instruction is in a delay slot
- hw_int  in  HW_INT_N  asynchronous hardware interrupts
- cp0_status  in  32  CP0 Status
- cp0_cause  in  32  CP0 Cause (software IP in [9:8])
- cp0_epc  in  32  CP0 EPC
- except_type  out  32  registered type code of the last commit
- exc_code  out  5  registered ExcCode of the last commit
- exc_valid  out  1  one-cycle commit pulse
- flush  out  1  pipeline flush
- new_pc  out  32  redirect target
- epc_out  out  32  EPC value to write
- badvaddr_out  out  32  BadVAddr value to write
- badvaddr_we  out  1  BadVAddr write enable, qualified by exc_valid
- bd_out  out  1  Cause.BD value to write
- ip_hw  out  HW_INT_N  synchronised interrupt pending, to Cause[10 +: HW_INT_N]

Behaviour:
- Reset: reset rst, synchronous, active-high. rst overrides every other input. All outputs and the synchroniser flops go to 0; the state machine goes to IDLE.
- Synchroniser: ip_hw is the last stage of a SYNC_STAGES-deep chain per line. It samples every cycle in every state.
- Interrupt request:
  - int_req = ((cp0_status[15:8] & {ip_hw zero-extended to 6 bits, cp0_cause[9:8]}) != 8'h00) && Status.EXL==0 && Status.IE==1.
  - The mask is a bitwise AND that is then compared to zero. No precedence shortcut.
- Priority, highest first (type / exc_code):
  1. int_req: 32'h1 / 0
  2. except_m[7] or [1]: 32'h4 / 4
  3. except_m[0]: 32'h5 / 5
  4. except_m[5]: 32'h8 / 8
  5. except_m[6]: 32'h9 / 9
  6. except_m[4]: 32'he / 0 (eret)
  7. except_m[3]: 32'ha / 10
  8. except_m[2]: 32'hc / 12
  9. otherwise no exception
- States: IDLE and FLUSH, with a 4-bit flush counter.
- IDLE commit condition: valid_m && !stall_m && resolved type != 0. On commit, in the next cycle:
  - exc_valid=1 for exactly one cycle.
  - flush=1.
  - except_type and exc_code take the resolved values.
  - new_pc = cp0_epc for eret, else EXC_VEC.
  - epc_out = in_ds_m ? pc_m - 4 : pc_m, wrapping modulo 2^32.
  - bd_out = in_ds_m.
  - badvaddr_out = pc_m for except_m[7]; bad_addr_m for except_m[1] or [0] (pc_m wins if both [7] and [1] are set).
  - badvaddr_we = 1 only for AdEL/AdES.
  - State moves to FLUSH with counter = FLUSH_CYCLES-1.
- Pending inputs: an interrupt or exception with valid_m=0 or stall_m=1 is not committed. It stays pending and commits in the first cycle the condition holds.
- FLUSH state:
  - flush stays high; exc_valid=0; all other inputs are ignored (that instruction is being flushed).
  - Counter decrements each cycle. At 0, flush drops the following cycle and the state returns to IDLE.
  - With FLUSH_CYCLES=1, flush is high for exactly one cycle.
- Register persistence: except_type, exc_code, new_pc, epc_out, badvaddr_out and bd_out hold until the next commit. badvaddr_we is only meaningful while exc_valid=1.
- Back-to-back: a commit is possible in the first IDLE cycle after FLUSH. The minimum spacing between commits is FLUSH_CYCLES+1 cycles.
- Reset mid-FLUSH: flush drops in the next cycle.

Test Plan:
- Store AdES: except_m=8'h01, bad_addr_m=32'h80001003, pc_m=32'hBFC00100, valid_m=1, in_ds_m=0 -> next cycle exc_valid=1, except_type=5, exc_code=5, badvaddr_out=32'h80001003, badvaddr_we=1, epc_out=32'hBFC00100, new_pc=32'hBFC00380.
- Syscall in a delay slot: except_m=8'h20, pc_m=32'hBFC00204, in_ds_m=1 -> epc_out=32'hBFC00200, bd_out=1, except_type=8, badvaddr_we=0.
- Interrupt beats RI: hw_int[0] held high, Status=32'h00000401, except_m=8'h08 -> after SYNC_STAGES cycles, ip_hw[0]=1. The next commit has except_type=1, exc_code=0. With Status.EXL=1 instead, except_type=32'ha.
- Eret under stall: except_m=8'h10, cp0_epc=32'hBFC00040, stall_m=1 for 3 cycles then 0 -> no exc_valid while stalled. Commit the cycle after release with new_pc=32'hBFC00040, except_type=32'he.
- FLUSH_CYCLES=3, Ov followed by Bp on the next two cycles -> flush high exactly 3 cycles and the Bp is ignored. A Bp presented in the first IDLE cycle commits with except_type=9.
- rst asserted while flush=1 -> the next cycle all outputs are 0 and the state is IDLE. A pending interrupt is re-taken only after the synchroniser refills.

Source files
------------

// File: rtl/except_ctrl_if.sv
// Bundle of MEM-stage exception inputs, CP0 views and commit outputs.
// The pipeline side drives through 'master'; the controller sits on 'slave'.
interface except_ctrl_if #(
  parameter int HW_INT_N = 6
);
  logic                valid_m;
  logic                stall_m;
  logic [7:0]          except_m;
  logic [31:0]         pc_m;
  logic [31:0]         bad_addr_m;
  logic                in_ds_m;
  logic [HW_INT_N-1:0] hw_int;
  logic [31:0]         cp0_status;
  logic [31:0]         cp0_cause;
  logic [31:0]         cp0_epc;

  logic [31:0]         except_type;
  logic [4:0]          exc_code;
  logic                exc_valid;
  logic                flush;
  logic [31:0]         new_pc;
  logic [31:0]         epc_out;
  logic [31:0]         badvaddr_out;
  logic                badvaddr_we;
  logic                bd_out;
  logic [HW_INT_N-1:0] ip_hw;

  modport master (
    output valid_m, stall_m, except_m, pc_m, bad_addr_m, in_ds_m,
           hw_int, cp0_status, cp0_cause, cp0_epc,
    input  except_type, exc_code, exc_valid, flush, new_pc, epc_out,
           badvaddr_out, badvaddr_we, bd_out, ip_hw
  );

  modport slave (
    input  valid_m, stall_m, except_m, pc_m, bad_addr_m, in_ds_m,
           hw_int, cp0_status, cp0_cause, cp0_epc,
    output except_type, exc_code, exc_valid, flush, new_pc, epc_out,
           badvaddr_out, badvaddr_we, bd_out, ip_hw
  );
endinterface

// File: rtl/except_ctrl.sv
// MEM-stage exception resolver and commit controller.
// Synchronises hardware interrupts, picks one exception by fixed priority,
// and on commit emits a one-cycle pulse, a multi-cycle flush, the redirect
// PC and the values CP0 should latch (EPC, BadVAddr, BD, ExcCode).
module except_ctrl #(
  parameter int          HW_INT_N     = 6,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VEC      = 32'hBFC00380
) (
  input logic         clk,
  input logic         rst,
  except_ctrl_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  localparam logic [31:0] T_INT  = 32'h0000_0001;
  localparam logic [31:0] T_ADEL = 32'h0000_0004;
  localparam logic [31:0] T_ADES = 32'h0000_0005;
  localparam logic [31:0] T_SYS  = 32'h0000_0008;
  localparam logic [31:0] T_BP   = 32'h0000_0009;
  localparam logic [31:0] T_RI   = 32'h0000_000a;
  localparam logic [31:0] T_OV   = 32'h0000_000c;
  localparam logic [31:0] T_ERET = 32'h0000_000e;

  logic [HW_INT_N-1:0] r_sync [SYNC_STAGES];

  logic [0:0]  r_state;
  logic [3:0]  r_flushCnt;
  logic        r_excValid;
  logic        r_flush;
  logic [31:0] r_exceptType;
  logic [4:0]  r_excCode;
  logic [31:0] r_newPc;
  logic [31:0] r_epcOut;
  logic [31:0] r_badvaddrOut;
  logic        r_badvaddrWe;
  logic        r_bdOut;

  logic [HW_INT_N-1:0] w_ipHw;
  logic [5:0]          w_ipHw6;
  logic [7:0]          w_pending;
  logic                w_intReq;
  logic [31:0]         w_type;
  logic [4:0]          w_code;
  logic                w_isAddr;
  logic                w_isEret;
  logic [31:0]         w_badv;
  logic [31:0]         w_epc;
  logic                w_commit;

  // Per-line synchroniser chain; runs every cycle regardless of FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= bus.hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_ipHw = r_sync[SYNC_STAGES-1];

  // Widen the synchronised lines to the six hardware IP slots
  always_comb begin
    w_ipHw6 = '0;
    w_ipHw6[HW_INT_N-1:0] = w_ipHw;
  end

  assign w_pending = bus.cp0_status[15:8] & {w_ipHw6, bus.cp0_cause[9:8]};
  assign w_intReq  = (w_pending != 8'h00) && !bus.cp0_status[1] && bus.cp0_status[0];

  // Fixed-priority resolution of the exception type and its ExcCode
  always_comb begin
    w_type = '0;
    w_code = '0;
    if (w_intReq) begin
      w_type = T_INT;
      w_code = 5'd0;
    end else if (bus.except_m[7] || bus.except_m[1]) begin
      w_type = T_ADEL;
      w_code = 5'd4;
    end else if (bus.except_m[0]) begin
      w_type = T_ADES;
      w_code = 5'd5;
    end else if (bus.except_m[5]) begin
      w_type = T_SYS;
      w_code = 5'd8;
    end else if (bus.except_m[6]) begin
      w_type = T_BP;
      w_code = 5'd9;
    end else if (bus.except_m[4]) begin
      w_type = T_ERET;
      w_code = 5'd0;
    end else if (bus.except_m[3]) begin
      w_type = T_RI;
      w_code = 5'd10;
    end else if (bus.except_m[2]) begin
      w_type = T_OV;
      w_code = 5'd12;
    end
  end

  assign w_isAddr = (w_type == T_ADEL) || (w_type == T_ADES);
  assign w_isEret = (w_type == T_ERET);
  assign w_badv   = bus.except_m[7] ? bus.pc_m : bus.bad_addr_m;
  assign w_epc    = bus.in_ds_m ? (bus.pc_m - 32'd4) : bus.pc_m;
  assign w_commit = (r_state == S_IDLE) && bus.valid_m && !bus.stall_m && (w_type != 32'h0);

  // Commit/flush state machine and the registered CP0 write values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_flushCnt    <= '0;
      r_excValid    <= 1'b0;
      r_flush       <= 1'b0;
      r_exceptType  <= '0;
      r_excCode     <= '0;
      r_newPc       <= '0;
      r_epcOut      <= '0;
      r_badvaddrOut <= '0;
      r_badvaddrWe  <= 1'b0;
      r_bdOut       <= 1'b0;
    end else begin
      r_excValid   <= 1'b0;
      r_badvaddrWe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_commit) begin
            r_excValid   <= 1'b1;
            r_flush      <= 1'b1;
            r_exceptType <= w_type;
            r_excCode    <= w_code;
            r_newPc      <= w_isEret ? bus.cp0_epc : EXC_VEC;
            r_epcOut     <= w_epc;
            r_bdOut      <= bus.in_ds_m;
            r_badvaddrWe <= w_isAddr;
            if (w_isAddr) r_badvaddrOut <= w_badv;
            r_flushCnt   <= FLUSH_INIT;
            r_state      <= S_FLUSH;
          end else begin
            r_flush <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (r_flushCnt == 4'd0) begin
            r_flush <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_flushCnt <= r_flushCnt - 4'd1;
          end
        end
        default: begin
          r_flush <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.except_type  = r_exceptType;
  assign bus.exc_code     = r_excCode;
  assign bus.exc_valid    = r_excValid;
  assign bus.flush        = r_flush;
  assign bus.new_pc       = r_newPc;
  assign bus.epc_out      = r_epcOut;
  assign bus.badvaddr_out = r_badvaddrOut;
  assign bus.badvaddr_we  = r_badvaddrWe;
  assign bus.bd_out       = r_bdOut;
  assign bus.ip_hw        = w_ipHw;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: one instance with a single-cycle flush and
// one with a three-cycle flush, both fed the same stimulus.
module tb_except_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  except_ctrl_if #(.HW_INT_N(6)) ifA ();
  except_ctrl_if #(.HW_INT_N(6)) ifB ();

  except_ctrl #(.HW_INT_N(6), .SYNC_STAGES(2), .FLUSH_CYCLES(1)) dutA (
    .clk(clk), .rst(rst), .bus(ifA)
  );

  except_ctrl #(.HW_INT_N(6), .SYNC_STAGES(2), .FLUSH_CYCLES(3)) dutB (
    .clk(clk), .rst(rst), .bus(ifB)
  );

  // Mirror the stimulus of the first instance onto the second
  assign ifB.valid_m    = ifA.valid_m;
  assign ifB.stall_m    = ifA.stall_m;
  assign ifB.except_m   = ifA.except_m;
  assign ifB.pc_m       = ifA.pc_m;
  assign ifB.bad_addr_m = ifA.bad_addr_m;
  assign ifB.in_ds_m    = ifA.in_ds_m;
  assign ifB.hw_int     = ifA.hw_int;
  assign ifB.cp0_status = ifA.cp0_status;
  assign ifB.cp0_cause  = ifA.cp0_cause;
  assign ifB.cp0_epc    = ifA.cp0_epc;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic stall, input logic [7:0] exc,
                               input logic [31:0] pc, input logic [31:0] badAddr, input logic inDs);
    ifA.valid_m    = valid;
    ifA.stall_m    = stall;
    ifA.except_m   = exc;
    ifA.pc_m       = pc;
    ifA.bad_addr_m = badAddr;
    ifA.in_ds_m    = inDs;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic resetDut();
    idleInputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idleInputs();
    ifA.hw_int     = '0;
    ifA.cp0_status = 32'h0;
    ifA.cp0_cause  = 32'h0;
    ifA.cp0_epc    = 32'h0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_exc_valid", {31'h0, ifA.exc_valid}, 32'h0);
    checkOutput("rst_flush", {31'h0, ifA.flush}, 32'h0);
    checkOutput("rst_type", ifA.except_type, 32'h0);
    checkOutput("rst_new_pc", ifA.new_pc, 32'h0);
    checkOutput("rst_ip_hw", {26'h0, ifA.ip_hw}, 32'h0);
    rst = 1'b0;

    // Store AdES
    applyStimulus(1'b1, 1'b0, 8'h01, 32'hBFC00100, 32'h80001003, 1'b0);
    tick();
    checkOutput("ades_valid", {31'h0, ifA.exc_valid}, 32'h1);
    checkOutput("ades_flush", {31'h0, ifA.flush}, 32'h1);
    checkOutput("ades_type", ifA.except_type, 32'h5);
    checkOutput("ades_code", {27'h0, ifA.exc_code}, 32'h5);
    checkOutput("ades_badv", ifA.badvaddr_out, 32'h80001003);
    checkOutput("ades_badv_we", {31'h0, ifA.badvaddr_we}, 32'h1);
    checkOutput("ades_epc", ifA.epc_out, 32'hBFC00100);
    checkOutput("ades_new_pc", ifA.new_pc, 32'hBFC00380);
    idleInputs();
    tick();
    checkOutput("ades_pulse_end", {31'h0, ifA.exc_valid}, 32'h0);
    checkOutput("fc1_flush_end", {31'h0, ifA.flush}, 32'h0);
    checkOutput("fc3_flush_still", {31'h0, ifB.flush}, 32'h1);
    checkOutput("ades_badv_hold", ifA.badvaddr_out, 32'h80001003);

    // Syscall in a delay slot
    resetDut();
    applyStimulus(1'b1, 1'b0, 8'h20, 32'hBFC00204, 32'h0, 1'b1);
    tick();
    checkOutput("sys_valid", {31'h0, ifA.exc_valid}, 32'h1);
    checkOutput("sys_epc", ifA.epc_out, 32'hBFC00200);
    checkOutput("sys_bd", {31'h0, ifA.bd_out}, 32'h1);
    checkOutput("sys_type", ifA.except_type, 32'h8);
    checkOutput("sys_badv_we", {31'h0, ifA.badvaddr_we}, 32'h0);

    // Fetch AdEL beats load AdEL: BadVAddr takes the PC
    idleInputs();
    tick();
    applyStimulus(1'b1, 1'b0, 8'h82, 32'h00000003, 32'h12345678, 1'b0);
    tick();
    checkOutput("adel_type", ifA.except_type, 32'h4);
    checkOutput("adel_badv", ifA.badvaddr_out, 32'h00000003);
    checkOutput("adel_epc_plain", ifA.epc_out, 32'h00000003);

    // Interrupt beats RI once the synchroniser fills
    resetDut();
    ifA.hw_int     = 6'b000001;
    ifA.cp0_status = 32'h00000401;
    applyStimulus(1'b0, 1'b0, 8'h08, 32'hBFC00300, 32'h0, 1'b0);
    tick();
    checkOutput("sync_stage1", {26'h0, ifA.ip_hw}, 32'h0);
    tick();
    checkOutput("sync_stage2", {26'h0, ifA.ip_hw}, 32'h1);
    checkOutput("int_not_valid", {31'h0, ifA.exc_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h08, 32'hBFC00300, 32'h0, 1'b0);
    tick();
    checkOutput("int_valid", {31'h0, ifA.exc_valid}, 32'h1);
    checkOutput("int_type", ifA.except_type, 32'h1);
    checkOutput("int_code", {27'h0, ifA.exc_code}, 32'h0);
    idleInputs();
    tick();
    ifA.cp0_status = 32'h00000403;
    applyStimulus(1'b1, 1'b0, 8'h08, 32'hBFC00300, 32'h0, 1'b0);
    tick();
    checkOutput("exl_ri_type", ifA.except_type, 32'ha);
    checkOutput("exl_ri_code", {27'h0, ifA.exc_code}, 32'd10);

    // Eret held back by a stall
    ifA.hw_int     = '0;
    ifA.cp0_status = 32'h0;
    resetDut();
    ifA.cp0_epc = 32'hBFC00040;
    applyStimulus(1'b1, 1'b1, 8'h10, 32'hBFC00500, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("eret_stalled", {31'h0, ifA.exc_valid}, 32'h0);
    end
    ifA.stall_m = 1'b0;
    tick();
    checkOutput("eret_valid", {31'h0, ifA.exc_valid}, 32'h1);
    checkOutput("eret_new_pc", ifA.new_pc, 32'hBFC00040);
    checkOutput("eret_type", ifA.except_type, 32'he);

    // Three-cycle flush: Bp ignored while flushing, taken in first idle cycle
    resetDut();
    applyStimulus(1'b1, 1'b0, 8'h04, 32'hBFC00600, 32'h0, 1'b0);
    tick();
    checkOutput("ov_valid", {31'h0, ifB.exc_valid}, 32'h1);
    checkOutput("ov_type", ifB.except_type, 32'hc);
    checkOutput("ov_flush1", {31'h0, ifB.flush}, 32'h1);
    applyStimulus(1'b1, 1'b0, 8'h40, 32'hBFC00604, 32'h0, 1'b0);
    tick();
    checkOutput("ov_flush2", {31'h0, ifB.flush}, 32'h1);
    checkOutput("bp_ignored1", {31'h0, ifB.exc_valid}, 32'h0);
    tick();
    checkOutput("ov_flush3", {31'h0, ifB.flush}, 32'h1);
    checkOutput("bp_ignored2", {31'h0, ifB.exc_valid}, 32'h0);
    checkOutput("ov_type_hold", ifB.except_type, 32'hc);
    tick();
    checkOutput("ov_flush_drop", {31'h0, ifB.flush}, 32'h0);
    checkOutput("bp_ignored3", {31'h0, ifB.exc_valid}, 32'h0);
    tick();
    checkOutput("bp_valid", {31'h0, ifB.exc_valid}, 32'h1);
    checkOutput("bp_type", ifB.except_type, 32'h9);
    checkOutput("bp_code", {27'h0, ifB.exc_code}, 32'h9);

    // Reset during flush, then interrupt retaken after the synchroniser refills
    resetDut();
    ifA.hw_int     = 6'b000001;
    ifA.cp0_status = 32'h00000401;
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 8'h00, 32'hBFC00700, 32'h0, 1'b0);
    tick();
    checkOutput("mid_int_valid", {31'h0, ifB.exc_valid}, 32'h1);
    checkOutput("mid_flush_high", {31'h0, ifB.flush}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_flush", {31'h0, ifB.flush}, 32'h0);
    checkOutput("mid_rst_type", ifB.except_type, 32'h0);
    checkOutput("mid_rst_ip_hw", {26'h0, ifB.ip_hw}, 32'h0);
    checkOutput("mid_rst_epc", ifB.epc_out, 32'h0);
    tick();
    checkOutput("refill1_no_commit", {31'h0, ifB.exc_valid}, 32'h0);
    tick();
    checkOutput("refill2_no_commit", {31'h0, ifB.exc_valid}, 32'h0);
    checkOutput("refill2_ip_hw", {26'h0, ifB.ip_hw}, 32'h1);
    tick();
    checkOutput("retake_valid", {31'h0, ifB.exc_valid}, 32'h1);
    checkOutput("retake_type", ifB.except_type, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
